// File: rtl/inv_request_ctrl.sv
// Request front-end for the Fp Montgomery inverter: filters zero operands, issues start pulses, returns tagged results.
// Optional watchdog/abort path is compiled in when INV_TIMEOUT_EN is defined.
module inv_request_ctrl #(
    parameter int W       = 446,
    parameter int TAG_W   = 2,
    parameter int TIMEOUT = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_c,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err,
    output logic             inv_start,
    output logic [W-1:0]     inv_a,
    input  logic [W-1:0]     inv_c,
    input  logic             inv_comp,
    output logic             inv_rst_n
);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ZERO    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
`ifdef INV_TIMEOUT_EN
        S_ABORT,
`endif
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic   req_zero;

    assign req_zero = ~|req_a;

`ifdef INV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             abort_cnt;

    // Watchdog counts WAIT cycles (saturating); abort_cnt times the two-cycle abort reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            abort_cnt <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)
                wd_cnt <= '0;
            else if (state_q == S_WAIT && wd_cnt != '1)
                wd_cnt <= wd_cnt + 1'b1;
            abort_cnt <= (state_q == S_ABORT) ? ~abort_cnt : 1'b0;
        end
    end

    assign inv_rst_n = (state_q != S_ABORT);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign inv_rst_n      = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // A completion pulse is honoured only in WAIT, and beats a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = req_zero ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (inv_comp)
                    state_d = S_RESP;
`ifdef INV_TIMEOUT_EN
                else if (wd_cnt == WD_LAST)
                    state_d = S_ABORT;
`endif
            end
`ifdef INV_TIMEOUT_EN
            S_ABORT: if (abort_cnt) state_d = S_RESP;
`endif
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response fields are only written on entry paths into RESP, so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_a   <= '0;
            rsp_c   <= '0;
            rsp_tag <= '0;
            rsp_err <= ERR_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        inv_a   <= req_a;
                        rsp_tag <= req_tag;
                        if (req_zero) begin
                            rsp_c   <= '0;
                            rsp_err <= ERR_ZERO;
                        end
                    end
                end
                S_WAIT: begin
                    if (inv_comp) begin
                        rsp_c   <= inv_c;
                        rsp_err <= ERR_OK;
                    end
                end
`ifdef INV_TIMEOUT_EN
                S_ABORT: begin
                    if (abort_cnt) begin
                        rsp_c   <= '0;
                        rsp_err <= ERR_TIMEOUT;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign inv_start = (state_q == S_ISSUE);
    assign rsp_valid = (state_q == S_RESP);

endmodule
